fcc_dist_cmp_pipe: RTL and testbench

- Parametrised squared-distance and epsilon-compare pipeline for the FCC LiDAR clustering datapath.
- Streams candidate points B against a query point A with valid/ready backpressure, 3-cycle latency and full throughput.
- Flags each candidate with dist2 <= eps2 and carries a caller tag through the pipe.
- Accumulates a per-batch neighbour count, reported on the beat marked last.

---
 rtl/fcc_pkg.sv | 26 ++
 rtl/fcc_sq_diff.sv | 33 +++
 rtl/fcc_dist_cmp_pipe.sv | 111 +++++++++++
 tb/tb_fcc_dist_cmp_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fcc_pkg.sv
// Shared constants and helpers for the FCC clustering datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
package fcc_pkg;

    localparam int FCC_W    = 16;
    localparam int FCC_TAGW = 16;
    localparam int FCC_CNTW = 16;

    // Width that holds 3*(2^w-1)^2, the largest possible squared distance.
    function automatic int fcc_dw(input int w);
        return 2 * w + 2;
    endfunction

    // Saturating-increment step. It returns 1 when the counter should
    // advance: inc is set and cnt is still below 2^cntw-1. The caller adds
    // the result to its own cntw-bit counter. cntw must be between 1 and 32.
    function automatic logic fcc_sat_inc_en(input logic [31:0] cnt,
                                            input logic        inc,
                                            input int          cntw);
        logic [32:0] max_val;
        max_val = (33'd1 << cntw) - 33'd1;
        return inc && ({1'b0, cnt} < max_val);
    endfunction

endpackage

// File: rtl/fcc_sq_diff.sv
// One-axis squared difference: S1 subtracts, S2 squares.
// Latency: 2 cycles of i_adv.
// Backpressure: both stages hold while i_adv is low.
module fcc_sq_diff #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                i_adv,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic [2*W-1:0]      o_sq
);

    logic signed [W:0]     r_diff;
    logic [2*W-1:0]        r_sq;
    logic signed [2*W-1:0] w_dext;
    logic [2*W-1:0]        w_sq;

    // The sign-extended result of the W+1 bit subtraction cannot overflow.
    // |diff| <= 2^W-1, so the square fits in 2W bits without sign.
    assign w_dext = {{(W-1){r_diff[W]}}, r_diff};
    assign w_sq   = w_dext * w_dext;
    assign o_sq   = r_sq;

    // S1 difference and S2 square. Each stage advances with the pipe.
    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_diff <= {i_a[W-1], i_a} - {i_b[W-1], i_b};
            r_sq   <= w_sq;
        end
    end

endmodule

// File: rtl/fcc_dist_cmp_pipe.sv
// Squared distance of candidate B to query A, compared with eps2 and counted per batch.
// Latency: 3 cycles. Throughput: 1 beat per cycle.
// Backpressure: global stall. in_ready = !out_valid | out_ready, and every stage holds when it is low.
module fcc_dist_cmp_pipe
    import fcc_pkg::*;
#(
    parameter int  W    = FCC_W,
    parameter int  TAGW = FCC_TAGW,
    parameter int  CNTW = FCC_CNTW,
    localparam int DW   = fcc_dw(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [TAGW-1:0]     in_tag,
    input  logic signed [W-1:0] ax,
    input  logic signed [W-1:0] ay,
    input  logic signed [W-1:0] az,
    input  logic signed [W-1:0] bx,
    input  logic signed [W-1:0] by,
    input  logic signed [W-1:0] bz,
    input  logic [DW-1:0]       eps2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_dist2,
    output logic                out_within,
    output logic [TAGW-1:0]     out_tag,
    output logic                out_last,
    output logic [CNTW-1:0]     out_count
);

    logic            w_adv;
    logic [2*W-1:0]  w_sqx, w_sqy, w_sqz;
    logic [DW-1:0]   w_sum;
    logic            w_within;
    logic [CNTW-1:0] w_cnt_next;

    // Sideband bits travel next to the axis data. Each stage has its own valid bit.
    logic            r_v1, r_v2;
    logic [TAGW-1:0] r_tag1, r_tag2;
    logic            r_last1, r_last2;
    logic [DW-1:0]   r_eps1, r_eps2;
    logic [CNTW-1:0] r_cnt;

    logic            r_out_valid;
    logic [DW-1:0]   r_out_dist2;
    logic            r_out_within;
    logic [TAGW-1:0] r_out_tag;
    logic            r_out_last;
    logic [CNTW-1:0] r_out_count;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    fcc_sq_diff #(.W(W)) u_sq_x (.clk(clk), .i_adv(w_adv), .i_a(ax), .i_b(bx), .o_sq(w_sqx));
    fcc_sq_diff #(.W(W)) u_sq_y (.clk(clk), .i_adv(w_adv), .i_a(ay), .i_b(by), .o_sq(w_sqy));
    fcc_sq_diff #(.W(W)) u_sq_z (.clk(clk), .i_adv(w_adv), .i_a(az), .i_b(bz), .o_sq(w_sqz));

    assign w_sum      = DW'(w_sqx) + DW'(w_sqy) + DW'(w_sqz);
    assign w_within   = (w_sum <= r_eps2);
    assign w_cnt_next = r_cnt + CNTW'(fcc_sat_inc_en(32'(r_cnt), w_within, CNTW));

    // Move valid, tag, last and eps2 through S1 and S2. Load the S3 outputs and update the batch count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_tag1       <= '0;
            r_tag2       <= '0;
            r_last1      <= 1'b0;
            r_last2      <= 1'b0;
            r_eps1       <= '0;
            r_eps2       <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_dist2  <= '0;
            r_out_within <= 1'b0;
            r_out_tag    <= '0;
            r_out_last   <= 1'b0;
            r_out_count  <= '0;
        end else if (w_adv) begin
            r_v1        <= in_valid;
            r_tag1      <= in_tag;
            r_last1     <= in_last;
            r_eps1      <= eps2;
            r_v2        <= r_v1;
            r_tag2      <= r_tag1;
            r_last2     <= r_last1;
            r_eps2      <= r_eps1;
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_out_dist2  <= w_sum;
                r_out_within <= w_within;
                r_out_tag    <= r_tag2;
                r_out_last   <= r_last2;
                r_out_count  <= w_cnt_next;
                r_cnt        <= r_last2 ? '0 : w_cnt_next;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_dist2  = r_out_dist2;
    assign out_within = r_out_within;
    assign out_tag    = r_out_tag;
    assign out_last   = r_out_last;
    assign out_count  = r_out_count;

endmodule

// File: tb/tb_fcc_dist_cmp_pipe.sv
// Scoreboard bench: directed beats push expected results, and a negedge monitor pops and compares them.
// dut1 uses the default widths. dut2 uses CNTW=2 for the saturation case.
// in_valid is steered to one of the two DUTs by sel2. out_ready is shared.
module tb_fcc_dist_cmp_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_last, sel2;
    logic [15:0]        in_tag;
    logic signed [15:0] ax, ay, az, bx, by, bz;
    logic [33:0]        eps2;
    logic               out_ready;

    logic rdy1, ov1, w1, lst1; logic [33:0] d1; logic [15:0] tg1; logic [15:0] c1;
    logic rdy2, ov2, w2, lst2; logic [33:0] d2; logic [15:0] tg2; logic [1:0]  c2;
    logic in_ready;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [33:0] d;
        logic        w;
        logic [15:0] tag;
        logic        last;
        logic [15:0] cnt;
        int          cyc;
        logic        lat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   mcnt1 = 0;
    int   mcnt2 = 0;
    logic        hold_vld [1:2];
    logic [67:0] hold_snap[1:2];

    fcc_dist_cmp_pipe dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel2), .in_ready(rdy1),
        .in_last(in_last), .in_tag(in_tag), .ax(ax), .ay(ay), .az(az),
        .bx(bx), .by(by), .bz(bz), .eps2(eps2), .out_valid(ov1), .out_ready(out_ready),
        .out_dist2(d1), .out_within(w1), .out_tag(tg1), .out_last(lst1), .out_count(c1));

    fcc_dist_cmp_pipe #(.CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel2), .in_ready(rdy2),
        .in_last(in_last), .in_tag(in_tag), .ax(ax), .ay(ay), .az(az),
        .bx(bx), .by(by), .bz(bz), .eps2(eps2), .out_valid(ov2), .out_ready(out_ready),
        .out_dist2(d2), .out_within(w2), .out_tag(tg2), .out_last(lst2), .out_count(c2));

    assign in_ready = sel2 ? rdy2 : rdy1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon_one(input int id, input logic ov, input logic [33:0] d, input logic w,
                           input logic [15:0] tg, input logic lst, input logic [15:0] c);
        exp_t e;
        logic [67:0] snap;
        logic empty;
        snap = {d, w, tg, lst, c};
        if (hold_vld[id] && ov) cmp("hold_stable", 72'(snap), 72'(hold_snap[id]));
        if (ov && out_ready) begin
            hold_vld[id] = 1'b0;
            empty = (id == 1) ? (q1.size() == 0) : (q2.size() == 0);
            if (empty) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat dut%0d: got tag %0d, expected no beat", id, tg);
            end else begin
                e = (id == 1) ? q1.pop_front() : q2.pop_front();
                cmp("dist2", 72'(d), 72'(e.d));
                cmp("within", 72'(w), 72'(e.w));
                cmp("tag", 72'(tg), 72'(e.tag));
                cmp("last", 72'(lst), 72'(e.last));
                cmp("count", 72'(c), 72'(e.cnt));
                if (e.lat) cmp("latency", 72'(cyc), 72'(e.cyc + 3));
            end
        end else begin
            hold_vld[id]  = ov;
            hold_snap[id] = snap;
        end
    endtask

    // Monitor: check ready against the stall rule, output hold, and scoreboard order.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld[1] = 1'b0;
            hold_vld[2] = 1'b0;
        end else begin
            cmp("in_ready_adv", 72'(rdy1), 72'(!ov1 || out_ready));
            mon_one(1, ov1, d1, w1, tg1, lst1, c1);
            mon_one(2, ov2, d2, w2, tg2, lst2, {14'd0, c2});
        end
    end

    task automatic send(input logic s2, input logic signed [15:0] xa, input logic signed [15:0] ya,
                        input logic signed [15:0] za, input logic signed [15:0] xb,
                        input logic signed [15:0] yb, input logic signed [15:0] zb,
                        input logic [33:0] e2, input logic [15:0] tag, input logic last,
                        input logic [33:0] exp_d, input logic lat);
        exp_t e;
        logic acc;
        sel2 = s2; ax = xa; ay = ya; az = za; bx = xb; by = yb; bz = zb;
        eps2 = e2; in_tag = tag; in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc    = 1'b1;
                e.d    = exp_d;
                e.w    = (exp_d <= e2);
                e.tag  = tag;
                e.last = last;
                e.cyc  = cyc;
                e.lat  = lat;
                if (s2) begin
                    if (e.w && mcnt2 < 3) mcnt2++;
                    e.cnt = 16'(mcnt2);
                    if (last) mcnt2 = 0;
                    q2.push_back(e);
                end else begin
                    if (e.w && mcnt1 < 65535) mcnt1++;
                    e.cnt = 16'(mcnt1);
                    if (last) mcnt1 = 0;
                    q1.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!acc) cmp("accept_timeout", 72'(0), 72'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (q1.size() + q2.size()) != 0; t++) @(posedge clk);
        #1;
        cmp("drain_empty", 72'(q1.size() + q2.size()), 72'(0));
    endtask

    logic [5:0] rdy_pat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; sel2 = 1'b0; in_tag = '0;
        ax = '0; ay = '0; az = '0; bx = '0; by = '0; bz = '0; eps2 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("rst_out_valid", 72'(ov1), 72'(0));
        cmp("rst_out_dist2", 72'(d1), 72'(0));
        cmp("rst_out_within", 72'(w1), 72'(0));
        cmp("rst_out_tag", 72'(tg1), 72'(0));
        cmp("rst_out_last", 72'(lst1), 72'(0));
        cmp("rst_out_count", 72'(c1), 72'(0));
        @(posedge clk); #1;

        // Single beats: inclusive compare and latency.
        send(0, 1, 2, 3, 4, 6, 3, 34'd25, 16'h00A1, 1, 34'd25, 1);
        drain();
        send(0, 1, 2, 3, 4, 6, 3, 34'd24, 16'h00A2, 1, 34'd25, 1);
        drain();
        send(0, -7, 5, 9, -7, 5, 9, 34'd0, 16'h00A3, 1, 34'd0, 1);
        drain();

        // 8 back-to-back beats, dist2 = k^2, eps2 = 10.
        for (int k = 0; k < 8; k++)
            send(0, 3, -4, 2, 16'(3 + k), -4, 2, 34'd10, 16'(16'h0010 + k), (k == 7), 34'(k * k), 1);
        drain();

        // 6-beat stream while out_ready follows 1,0,0,1,0,1. dist2 = 3k^2, eps2 = 12.
        rdy_pat = 6'b101001;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(0, 0, 0, 0, 16'(k), 16'(k), 16'(k), 34'd12, 16'(16'h0020 + k), (k == 5), 34'(3 * k * k), 0);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    out_ready = rdy_pat[i];
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        // Within pattern 1,0,1,1,0 then a new 2-beat batch, eps2 = 4.
        send(0, 10, 0, 0, 11, 0, 0, 34'd4, 16'h0031, 0, 34'd1, 1);
        send(0, 10, 0, 0, 13, 0, 0, 34'd4, 16'h0032, 0, 34'd9, 1);
        send(0, 10, 0, 0, 12, 0, 0, 34'd4, 16'h0033, 0, 34'd4, 1);
        send(0, 10, 0, 0, 10, 0, 0, 34'd4, 16'h0034, 0, 34'd0, 1);
        send(0, 10, 0, 0, 15, 0, 0, 34'd4, 16'h0035, 1, 34'd25, 1);
        send(0, 10, 0, 0, 10, 0, 0, 34'd4, 16'h0036, 0, 34'd0, 1);
        send(0, 10, 0, 0, 11, 0, 0, 34'd4, 16'h0037, 1, 34'd1, 1);
        drain();

        // CNTW=2: six within beats saturate the count at 3.
        for (int k = 0; k < 6; k++)
            send(1, 1, 1, 1, 2, 1, 1, 34'd5, 16'(16'h0040 + k), (k == 5), 34'd1, 1);
        drain();

        // Coordinate extremes: 3*65535^2.
        send(0, -32768, -32768, -32768, 32767, 32767, 32767, 34'd12884508675, 16'h0051, 1, 34'd12884508675, 1);
        send(0, -32768, -32768, -32768, 32767, 32767, 32767, 34'd12884508674, 16'h0052, 1, 34'd12884508675, 1);
        drain();

        // Reset with a batch count of 2 and 2 beats in flight.
        send(0, 0, 0, 0, 1, 0, 0, 34'd9, 16'h0061, 0, 34'd1, 1);
        send(0, 0, 0, 0, 2, 0, 0, 34'd9, 16'h0062, 0, 34'd4, 1);
        drain();
        send(0, 0, 0, 0, 1, 1, 0, 34'd9, 16'h0063, 0, 34'd2, 0);
        send(0, 0, 0, 0, 1, 1, 1, 34'd9, 16'h0064, 0, 34'd3, 0);
        rst = 1'b1;
        q1.delete();
        mcnt1 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(0, 0, 0, 0, 0, 3, 0, 34'd9, 16'h0065, 1, 34'd9, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
